// File: rtl/elbeth_mem_arbiter.sv
// elbeth_mem_arbiter: shares one memory port between an instruction port and
// a data port. One grant at a time, zero-latency response forwarding, an
// alternating tie-break so neither requester starves, and a bounded wait on
// the memory response.
module elbeth_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  // instruction port request / response
  input  logic [31:0] imem_addr,
  input  logic [31:0] imem_out_data,
  input  logic [3:0]  imem_rw,
  input  logic        imem_en,
  output logic [31:0] imem_in_data,
  output logic        imem_ready,
  output logic        imem_error,
  // data port request / response
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_out_data,
  input  logic [3:0]  dmem_rw,
  input  logic        dmem_en,
  output logic [31:0] dmem_in_data,
  output logic        dmem_ready,
  output logic        dmem_error,
  // shared memory request / response
  output logic [31:0] mem_addr,
  output logic [31:0] mem_out_data,
  output logic [3:0]  mem_rw,
  output logic        mem_en,
  input  logic [31:0] mem_in_data,
  input  logic        mem_ready,
  input  logic        mem_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  // last_grant encoding: 0 = instruction port, 1 = data port
  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       last_grant_q, last_grant_d;

  logic       timeout_hit;
  logic       sel_en;

  // Abort condition: waited the full budget and memory still silent.
  always_comb begin
    timeout_hit = (state_q != IDLE) && (cnt_q == TIMEOUT_C) && !mem_ready && !mem_error;
  end

  // Enable of whichever port currently owns the memory.
  always_comb begin
    sel_en = 1'b0;
    case (state_q)
      GNT_I:   sel_en = imem_en;
      GNT_D:   sel_en = dmem_en;
      default: sel_en = 1'b0;
    endcase
  end

  // Next-state: arbitration in IDLE, completion/withdraw/timeout in a grant.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (imem_en && dmem_en) begin
          // Tie: data port wins unless it was served last.
          if (last_grant_q == LAST_D) begin
            state_d      = GNT_I;
            last_grant_d = LAST_I;
          end else begin
            state_d      = GNT_D;
            last_grant_d = LAST_D;
          end
          cnt_d = 8'd0;
        end else if (imem_en) begin
          state_d      = GNT_I;
          last_grant_d = LAST_I;
          cnt_d        = 8'd0;
        end else if (dmem_en) begin
          state_d      = GNT_D;
          last_grant_d = LAST_D;
          cnt_d        = 8'd0;
        end
      end
      GNT_I, GNT_D: begin
        if (!sel_en || mem_ready || mem_error || timeout_hit) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, wait counter and tie-break history; async active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      last_grant_q <= LAST_I;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Output mux: route the owner's request out and the memory response back;
  // everything not owned stays at zero. A withdrawn requester sees nothing.
  always_comb begin
    mem_addr     = 32'd0;
    mem_out_data = 32'd0;
    mem_rw       = 4'd0;
    mem_en       = 1'b0;
    imem_in_data = 32'd0;
    imem_ready   = 1'b0;
    imem_error   = 1'b0;
    dmem_in_data = 32'd0;
    dmem_ready   = 1'b0;
    dmem_error   = 1'b0;
    case (state_q)
      GNT_I: begin
        mem_addr     = imem_addr;
        mem_out_data = imem_out_data;
        mem_rw       = imem_rw;
        mem_en       = imem_en && !timeout_hit;
        imem_in_data = mem_in_data;
        imem_ready   = imem_en && mem_ready;
        imem_error   = imem_en && (mem_error || timeout_hit);
      end
      GNT_D: begin
        mem_addr     = dmem_addr;
        mem_out_data = dmem_out_data;
        mem_rw       = dmem_rw;
        mem_en       = dmem_en && !timeout_hit;
        dmem_in_data = mem_in_data;
        dmem_ready   = dmem_en && mem_ready;
        dmem_error   = dmem_en && (mem_error || timeout_hit);
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

endmodule
